// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the fetch stage and its neighbours:
//   XLEN / ILEN      - address and instruction widths
//   NOP_INSTR_C      - canonical NOP (addi x0,x0,0) shown on a fetch fault
//   RESET_PC_C       - default PC loaded on reset
//   fetch_state_t    - fetch FSM states
//   is_misaligned()  - true when a byte address is not word aligned
// -----------------------------------------------------------------------------
package core_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INSTR_C = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_C  = 64'h0000_0000_0000_0000;

   typedef enum logic [2:0] {
      REQ   = 3'd0,
      WAIT  = 3'd1,
      HOLD  = 3'd2,
      DRAIN = 3'd3,
      FAULT = 3'd4
   } fetch_state_t;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Bundles the three handshakes of the fetch stage:
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata - instruction memory
//   redirect_valid/redirect_pc                         - branch/jump resolution
//   id_valid/id_ready/instruction/id_pc/fetch_fault    - decode
// Modports:
//   master - the fetch stage itself
//   slave  - the environment (memory, redirect source, decode)
//
// Handshake rules:
//   memory : a request is accepted on a cycle with imem_req & imem_gnt; exactly
//            one imem_rvalid follows each accepted request, in a later cycle.
//            An ungranted request may be withdrawn.
//   decode : an instruction transfers on a cycle with id_valid & id_ready;
//            while id_valid=1 and id_ready=0 the presented fields stay stable.
// -----------------------------------------------------------------------------
interface if_stage_if;
   import core_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [ILEN-1:0] imem_rdata;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   logic            id_valid;
   logic            id_ready;
   logic [ILEN-1:0] instruction;
   logic [XLEN-1:0] id_pc;
   logic            fetch_fault;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redirect_valid, redirect_pc,
      output id_valid, instruction, id_pc, fetch_fault,
      input  id_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redirect_valid, redirect_pc,
      input  id_valid, instruction, id_pc, fetch_fault,
      output id_ready
   );

endinterface

// File: rtl/if_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter of the fetch stage.
//   clk, rst  - clock, asynchronous active-low reset (loads RESET_PC)
//   load      - load load_pc (low two bits forced to zero); wins over inc
//   load_pc   - redirect target
//   inc       - advance by one instruction word (+4, wraps at 2^64)
//   pc        - current PC, always word aligned
// -----------------------------------------------------------------------------
module pc_reg
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_C
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   input  logic            inc,
   output logic [XLEN-1:0] pc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= {load_pc[XLEN-1:2], 2'b00};
      end else if (inc) begin
         pc <= pc + 64'd4;
      end
   end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: owns the PC, fetches one 32-bit word at a time from
// instruction memory and presents it with its PC to decode. Redirects override
// everything; a response that was already granted is drained and dropped.
// A misaligned redirect presents NOP_INSTR with fetch_fault=1 and parks in
// FAULT until an aligned redirect arrives.
//
// Ports:
//   clk          - core clock, rising edge
//   rst          - asynchronous active-low reset
//   bus          - if_stage_if.master (memory, redirect and decode handshakes)
//   dbg_state    - current FSM state, for observation
//   perf_fetched - (IF_PERF_CNT_EN only) instructions handed to decode
//   perf_stall   - (IF_PERF_CNT_EN only) cycles with id_valid & !id_ready
//
// Build option: define IF_PERF_CNT_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module if_stage
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_C,
   parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic         clk,
   input  logic         rst,
   if_stage_if.master   bus,
   output fetch_state_t dbg_state
`ifdef IF_PERF_CNT_EN
   ,
   output logic [63:0]  perf_fetched,
   output logic [63:0]  perf_stall
`endif
);

   fetch_state_t    state_q, state_d;
   logic            id_valid_q, id_valid_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] id_pc_q, id_pc_d;
   logic            fault_q, fault_d;
   // A misaligned redirect arrived while a response was still owed: enter
   // FAULT once DRAIN has swallowed that response.
   logic            pend_q, pend_d;
   logic            pc_inc;
   logic            owed;
   logic [XLEN-1:0] pc;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (bus.redirect_valid),
      .load_pc (bus.redirect_pc),
      .inc     (pc_inc),
      .pc      (pc)
   );

   // Gated by rst so no request leaves the block while reset is held.
   assign bus.imem_req    = rst & (state_q == REQ);
   assign bus.imem_addr   = pc;
   assign bus.id_valid    = id_valid_q;
   assign bus.instruction = instr_q;
   assign bus.id_pc       = id_pc_q;
   assign bus.fetch_fault = fault_q;
   assign dbg_state       = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= REQ;
         id_valid_q <= 1'b0;
         instr_q    <= '0;
         id_pc_q    <= '0;
         fault_q    <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_valid_q <= id_valid_d;
         instr_q    <= instr_d;
         id_pc_q    <= id_pc_d;
         fault_q    <= fault_d;
         pend_q     <= pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      id_valid_d = id_valid_q;
      instr_d    = instr_q;
      id_pc_d    = id_pc_q;
      fault_d    = fault_q;
      pend_d     = pend_q;
      pc_inc     = 1'b0;
      owed       = 1'b0;

      unique case (state_q)
         REQ: begin
            if (bus.imem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               instr_d    = bus.imem_rdata;
               id_pc_d    = pc;
               id_valid_d = 1'b1;
               pc_inc     = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (bus.id_ready) begin
               id_valid_d = 1'b0;
               state_d    = REQ;
            end
         end
         DRAIN: begin
            // The owed response is dropped; id_pc/instruction were already
            // loaded with the fault values when the redirect was taken.
            if (bus.imem_rvalid) begin
               pend_d = 1'b0;
               if (pend_q) begin
                  id_valid_d = 1'b1;
                  fault_d    = 1'b1;
                  state_d    = FAULT;
               end else begin
                  state_d = REQ;
               end
            end
         end
         FAULT: begin
            // Released only by an aligned redirect below.
         end
         default: state_d = REQ;
      endcase

      if (bus.redirect_valid) begin
         // A response is still owed if a grant happens now, or one was granted
         // earlier and its data has not shown up yet (this cycle included).
         owed = ((state_q == REQ)   &&  bus.imem_gnt)    ||
                ((state_q == WAIT)  && !bus.imem_rvalid) ||
                ((state_q == DRAIN) && !bus.imem_rvalid);
         pc_inc     = 1'b0;
         id_valid_d = 1'b0;
         fault_d    = 1'b0;
         pend_d     = 1'b0;
         if (is_misaligned(bus.redirect_pc)) begin
            instr_d = NOP_INSTR;
            id_pc_d = bus.redirect_pc;
            if (owed) begin
               pend_d  = 1'b1;
               state_d = DRAIN;
            end else begin
               id_valid_d = 1'b1;
               fault_d    = 1'b1;
               state_d    = FAULT;
            end
         end else begin
            state_d = owed ? DRAIN : REQ;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if ((state_q == HOLD) && id_valid_q && bus.id_ready && !bus.redirect_valid)
            perf_fetched <= perf_fetched + 64'd1;
         if (id_valid_q && !bus.id_ready)
            perf_stall <= perf_stall + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Inputs are driven 1 time unit after the rising
// edge and outputs are sampled there too, so every value seen is the settled
// result of the previous edge. Memory words are {16'hC0DE, addr[15:0]}.
// -----------------------------------------------------------------------------
module tb_if_stage;
   import core_pkg::*;

   logic         clk;
   logic         rst;
   fetch_state_t dbg_state;
`ifdef IF_PERF_CNT_EN
   logic [63:0]  perf_fetched;
   logic [63:0]  perf_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   if_stage_if bus ();

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.master),
      .dbg_state    (dbg_state)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks++;
      if ({bus.imem_req, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc, dbg_state} !==
          {1'b0, 1'b0, 1'b0, 32'h0, 64'h0, REQ}) begin
         n_fail++;
         $display("FAIL reset_state: req=%b v=%b ff=%b ins=%h pc=%h st=%0d want 0/0/0/0/0/REQ",
                  bus.imem_req, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc, dbg_state);
      end
`ifdef IF_PERF_CNT_EN
      n_checks++;
      if ({perf_fetched, perf_stall} !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_perf: fetched=%0d stall=%0d want 0/0", perf_fetched, perf_stall);
      end
`endif
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h0}) begin
         n_fail++;
         $display("FAIL reset_release_req: req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_fetch_seq();
      logic [63:0] a;
      time t_prev;
      t_prev = 0;
      for (int i = 0; i < 3; i++) begin
         a = 64'(i * 4);
         n_checks++;
         if ({bus.imem_req, bus.imem_addr} !== {1'b1, a}) begin
            n_fail++;
            $display("FAIL seq_req%0d: req=%b addr=%h want 1/%h", i, bus.imem_req, bus.imem_addr, a);
         end
         bus.imem_gnt = 1'b1;
         tick();
         bus.imem_gnt = 1'b0;
         n_checks++;
         if ({dbg_state, bus.imem_req} !== {WAIT, 1'b0}) begin
            n_fail++;
            $display("FAIL seq_wait%0d: st=%0d req=%b want WAIT/0", i, dbg_state, bus.imem_req);
         end
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = mem_word(a);
         tick();
         bus.imem_rvalid = 1'b0;
         n_checks++;
         if ({bus.id_valid, bus.instruction, bus.id_pc} !== {1'b1, mem_word(a), a}) begin
            n_fail++;
            $display("FAIL seq_out%0d: v=%b ins=%h pc=%h want 1/%h/%h",
                     i, bus.id_valid, bus.instruction, bus.id_pc, mem_word(a), a);
         end
         if (i > 0) begin
            n_checks++;
            if ($time - t_prev != 30) begin
               n_fail++;
               $display("FAIL seq_rate%0d: spacing=%0t want 30", i, $time - t_prev);
            end
         end
         t_prev = $time;
         bus.id_ready = 1'b1;
         tick();
         bus.id_ready = 1'b0;
      end
   endtask

   task automatic test_stall();
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h0050_0093;
      tick();
      bus.imem_rvalid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if ({bus.id_valid, bus.instruction, bus.id_pc, bus.imem_req} !==
             {1'b1, 32'h0050_0093, 64'hC, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: v=%b ins=%h pc=%h req=%b want 1/00500093/c/0",
                     k, bus.id_valid, bus.instruction, bus.id_pc, bus.imem_req);
         end
         tick();
      end
`ifdef IF_PERF_CNT_EN
      n_checks++;
      if ({perf_fetched, perf_stall} !== {64'd3, 64'd5}) begin
         n_fail++;
         $display("FAIL stall_perf: fetched=%0d stall=%0d want 3/5", perf_fetched, perf_stall);
      end
`endif
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.imem_addr} !== {REQ, 1'b0, 64'h10}) begin
         n_fail++;
         $display("FAIL stall_release: st=%0d v=%b addr=%h want REQ/0/10",
                  dbg_state, bus.id_valid, bus.imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt       = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h100;
      tick();
      bus.redirect_valid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.imem_req, bus.id_valid} !== {DRAIN, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rw_drain: st=%0d req=%b v=%b want DRAIN/0/0", dbg_state, bus.imem_req, bus.id_valid);
      end
      tick();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.imem_req, bus.imem_addr, bus.id_valid} !== {REQ, 1'b1, 64'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL rw_discard: st=%0d req=%b addr=%h v=%b want REQ/1/100/0",
                  dbg_state, bus.imem_req, bus.imem_addr, bus.id_valid);
      end
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(64'h100);
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({bus.id_valid, bus.instruction, bus.id_pc} !== {1'b1, mem_word(64'h100), 64'h100}) begin
         n_fail++;
         $display("FAIL rw_new: v=%b ins=%h pc=%h want 1/%h/100",
                  bus.id_valid, bus.instruction, bus.id_pc, mem_word(64'h100));
      end
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
   endtask

   task automatic test_redirect_gnt();
      bus.imem_gnt       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h200;
      tick();
      bus.imem_gnt       = 1'b0;
      bus.redirect_valid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.imem_req} !== {DRAIN, 1'b0}) begin
         n_fail++;
         $display("FAIL rg_drain: st=%0d req=%b want DRAIN/0", dbg_state, bus.imem_req);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h0BAD_0104;
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.imem_req, bus.imem_addr, bus.id_valid} !== {REQ, 1'b1, 64'h200, 1'b0}) begin
         n_fail++;
         $display("FAIL rg_req: st=%0d req=%b addr=%h v=%b want REQ/1/200/0",
                  dbg_state, bus.imem_req, bus.imem_addr, bus.id_valid);
      end
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(64'h200);
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({bus.id_valid, bus.instruction, bus.id_pc} !== {1'b1, mem_word(64'h200), 64'h200}) begin
         n_fail++;
         $display("FAIL rg_new: v=%b ins=%h pc=%h want 1/%h/200",
                  bus.id_valid, bus.instruction, bus.id_pc, mem_word(64'h200));
      end
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
   endtask

   task automatic test_redirect_hold();
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(64'h204);
      tick();
      bus.imem_rvalid    = 1'b0;
      bus.id_ready       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h500;
      tick();
      bus.id_ready       = 1'b0;
      bus.redirect_valid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.imem_addr} !== {REQ, 1'b0, 64'h500}) begin
         n_fail++;
         $display("FAIL rh_squash: st=%0d v=%b addr=%h want REQ/0/500", dbg_state, bus.id_valid, bus.imem_addr);
      end
`ifdef IF_PERF_CNT_EN
      n_checks++;
      if (perf_fetched !== 64'd6) begin
         n_fail++;
         $display("FAIL rh_perf: fetched=%0d want 6", perf_fetched);
      end
`endif
   endtask

   task automatic test_fault();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h102;
      tick();
      bus.redirect_valid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc, bus.imem_req} !==
          {FAULT, 1'b1, 1'b1, 32'h0000_0013, 64'h102, 1'b0}) begin
         n_fail++;
         $display("FAIL fault_enter: st=%0d v=%b ff=%b ins=%h pc=%h req=%b want FAULT/1/1/13/102/0",
                  dbg_state, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc, bus.imem_req);
      end
      bus.id_ready = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.fetch_fault} !== {FAULT, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL fault_sticky: st=%0d v=%b ff=%b want FAULT/1/1", dbg_state, bus.id_valid, bus.fetch_fault);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h300;
      tick();
      bus.redirect_valid = 1'b0;
      bus.id_ready       = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.fetch_fault, bus.imem_req, bus.imem_addr} !==
          {REQ, 1'b0, 1'b0, 1'b1, 64'h300}) begin
         n_fail++;
         $display("FAIL fault_exit: st=%0d v=%b ff=%b req=%b addr=%h want REQ/0/0/1/300",
                  dbg_state, bus.id_valid, bus.fetch_fault, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_fault_drain();
      bus.imem_gnt       = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'h306;
      tick();
      bus.imem_gnt       = 1'b0;
      bus.redirect_valid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.imem_req} !== {DRAIN, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL fd_drain: st=%0d v=%b req=%b want DRAIN/0/0", dbg_state, bus.id_valid, bus.imem_req);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc} !==
          {FAULT, 1'b1, 1'b1, 32'h0000_0013, 64'h306}) begin
         n_fail++;
         $display("FAIL fd_fault: st=%0d v=%b ff=%b ins=%h pc=%h want FAULT/1/1/13/306",
                  dbg_state, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      bus.redirect_valid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.fetch_fault, bus.imem_addr} !== {REQ, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC}) begin
         n_fail++;
         $display("FAIL fd_exit: st=%0d ff=%b addr=%h want REQ/0/fffffffffffffffc",
                  dbg_state, bus.fetch_fault, bus.imem_addr);
      end
   endtask

   task automatic test_wrap();
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({bus.id_valid, bus.id_pc} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
         n_fail++;
         $display("FAIL wrap_top: v=%b pc=%h want 1/fffffffffffffffc", bus.id_valid, bus.id_pc);
      end
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h0}) begin
         n_fail++;
         $display("FAIL wrap_zero: req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid_wait();
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.imem_req, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc, dbg_state} !==
          {1'b0, 1'b0, 1'b0, 32'h0, 64'h0, REQ}) begin
         n_fail++;
         $display("FAIL rst_async: req=%b v=%b ff=%b ins=%h pc=%h st=%0d want 0/0/0/0/0/REQ",
                  bus.imem_req, bus.id_valid, bus.fetch_fault, bus.instruction, bus.id_pc, dbg_state);
      end
      repeat (2) tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 64'h0}) begin
         n_fail++;
         $display("FAIL rst_rereq: req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({dbg_state, bus.id_valid, bus.imem_req, bus.imem_addr} !== {REQ, 1'b0, 1'b1, 64'h0}) begin
         n_fail++;
         $display("FAIL rst_late_rvalid: st=%0d v=%b req=%b addr=%h want REQ/0/1/0",
                  dbg_state, bus.id_valid, bus.imem_req, bus.imem_addr);
      end
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(64'h0);
      tick();
      bus.imem_rvalid = 1'b0;
      n_checks++;
      if ({bus.id_valid, bus.instruction, bus.id_pc} !== {1'b1, mem_word(64'h0), 64'h0}) begin
         n_fail++;
         $display("FAIL rst_refetch: v=%b ins=%h pc=%h want 1/%h/0",
                  bus.id_valid, bus.instruction, bus.id_pc, mem_word(64'h0));
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst                = 1'b0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b0;
      repeat (2) tick();

      test_reset();
      test_fetch_seq();
      test_stall();
      test_redirect_wait();
      test_redirect_gnt();
      test_redirect_hold();
      test_fault();
      test_fault_drain();
      test_wrap();
      test_reset_mid_wait();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
